// File: rtl/muldiv_pkg.sv
// Shared constants, op codes and state encoding for the RV32M multiply/divide sequencer.
package muldiv_pkg;

   localparam int XLEN = 32;
   localparam int ITER = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic rs1_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic rs2_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// The accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic                i_is_div,
   input  logic [2*XLEN-1:0]   i_acc,
   input  logic [XLEN-1:0]     i_opnd,
   output logic [2*XLEN-1:0]   o_acc
);

   logic [XLEN:0]   w_mul_sum;
   logic [XLEN:0]   w_div_shift;
   logic [XLEN-1:0] w_div_diff;
   logic            w_div_ge;

   always_comb begin
      w_mul_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
      w_div_shift = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
      w_div_ge    = (w_div_shift >= {1'b0, i_opnd});
      // remainder stays below the divisor, so the difference always fits XLEN bits
      w_div_diff  = w_div_shift[XLEN-1:0] - i_opnd;
      if (i_is_div) begin
         o_acc = {(w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0]), i_acc[XLEN-2:0], w_div_ge};
      end else begin
         o_acc = {w_mul_sum, i_acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer with start/ready handshake and one-cycle done pulse.
// MULDIV_FAST_MUL_EN: multiplies resolve at accept with a single combinational multiply.
//
// state   | meaning
// IDLE    | waiting for start, ready high
// BUSY    | iterating one step per clock
// DONE    | result valid, done pulse, ready high (back-to-back accept allowed)
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic            i_kill,
   output logic            o_ready,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = $clog2(ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_count;
   logic [2:0]          r_op;
   logic                r_neg;
   logic                r_neg_rem;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_opnd;
   logic [XLEN-1:0]     r_result;

   logic                w_accept;
   logic                w_is_div;
   logic                w_s1;
   logic                w_s2;
   logic [XLEN-1:0]     w_abs1;
   logic [XLEN-1:0]     w_abs2;
   logic                w_div0;
   logic                w_ovf;
   logic                w_special;
   logic [XLEN-1:0]     w_spec_res;
   logic [2*XLEN-1:0]   w_step;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_final;

   assign o_ready  = (r_state != ST_BUSY);
   assign o_done   = (r_state == ST_DONE);
   assign o_result = r_result;

   assign w_accept = i_start && o_ready && !i_kill;
   assign w_is_div = op_is_div(i_op);
   assign w_s1     = rs1_is_signed(i_op) & i_rs1[XLEN-1];
   assign w_s2     = rs2_is_signed(i_op) & i_rs2[XLEN-1];
   assign w_abs1   = w_s1 ? -i_rs1 : i_rs1;
   assign w_abs2   = w_s2 ? -i_rs2 : i_rs2;
   assign w_div0   = w_is_div && (i_rs2 == '0);
   assign w_ovf    = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_rs1 == INT_MIN) && (i_rs2 == '1);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     w_fa;
   logic signed [XLEN:0]     w_fb;
   logic signed [2*XLEN+1:0] w_fprod;

   assign w_fa    = {rs1_is_signed(i_op) & i_rs1[XLEN-1], i_rs1};
   assign w_fb    = {rs2_is_signed(i_op) & i_rs2[XLEN-1], i_rs2};
   assign w_fprod = w_fa * w_fb;
`endif

   always_comb begin
      w_special  = w_div0 | w_ovf;
      w_spec_res = '0;
      if (w_div0) begin
         w_spec_res = ((i_op == OP_DIV) || (i_op == OP_DIVU)) ? DIV0_Q : i_rs1;
      end else if (w_ovf) begin
         w_spec_res = (i_op == OP_DIV) ? INT_MIN : '0;
      end
`ifdef MULDIV_FAST_MUL_EN
      if (!w_is_div) begin
         w_special  = 1'b1;
         w_spec_res = (i_op == OP_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
      end
`endif
   end

   muldiv_step u_step (
      .i_is_div (op_is_div(r_op)),
      .i_acc    (r_acc),
      .i_opnd   (r_opnd),
      .o_acc    (w_step)
   );

   // sign correction applies to the accumulator after the final step
   always_comb begin
      w_prod = r_neg ? -w_step : w_step;
      w_quo  = r_neg ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
      w_rem  = r_neg_rem ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
      case (r_op)
         OP_MUL:                       w_final = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_final = w_quo;
         default:                      w_final = w_rem;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_op      <= '0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            ST_BUSY: begin
               if (i_kill) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_acc   <= w_step;
                  r_count <= r_count + 1'b1;
                  if (r_count == CNT_LAST) begin
                     r_state  <= ST_DONE;
                     r_result <= w_final;
                  end
               end
            end
            default: begin
               if (w_accept) begin
                  r_op      <= i_op;
                  r_neg     <= w_s1 ^ w_s2;
                  r_neg_rem <= w_s1;
                  r_count   <= '0;
                  r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
                  r_opnd    <= w_is_div ? w_abs2 : w_abs1;
                  if (w_special) begin
                     r_result <= w_spec_res;
                     r_state  <= ST_DONE;
                  end else begin
                     r_state  <= ST_BUSY;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule
